cardinal_nic: RTL
=================

Name: cardinal_nic

Overview:
- Network interface controller between one cardinal_processor node and its port on the 4-node cardinal ring router; one instance per node.
- Processor side: 2-bit addressed, 64-bit register window (addr_nic, din_nic, dout_nic, nicEn, nicWrEn).
- Router side: one-entry input buffer and one-entry output buffer, each with a ready/send handshake; injection is gated by the router's even/odd polarity.

Parameters:
- DATA_WIDTH, 64, packet and processor data width.
- VC_BIT, 0, index of the virtual-channel bit in a packet; compared against net_polarity.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- addr  input  [0:1]  register select from processor (node*_addr_nic).
- d_in  input  [0:63]  write data from processor (node*_din_nic).
- d_out  output  [0:63]  read data to processor (node*_dout_nic).
- nicEn  input  1  access enable.
- nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
- net_si  input  1  router sends a packet to this NIC.
- net_ri  output  1  NIC can accept a packet from the router.
- net_di  input  [0:63]  packet from router.
- net_so  output  1  NIC sends a packet to the router.
- net_ro  input  1  router can accept a packet.
- net_do  output  [0:63]  packet to router.
- net_polarity  input  1  router phase: 0 = even, 1 = odd.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Address map:
  - 00 = input buffer (read).
  - 01 = input status (read): {63'b0, in_full}.
  - 10 = output buffer (write).
  - 11 = output status (read): {63'b0, out_full}.
- Reset:
  - in_buf, out_buf, d_out all 0.
  - in_full = 0, out_full = 0.
  - net_so = 0 and net_ri = 0 while reset is high; net_do = 0.
- Processor read (nicEn=1, nicWrEn=0):
  - d_out is registered and valid one cycle after the request.
  - d_out holds its value when no read is issued.
  - A read of addr 00 returns in_buf and clears in_full on the same edge.
  - A read of addr 10 returns 0.
- Processor write (nicEn=1, nicWrEn=1, addr=10):
  - If out_full=0: out_buf <= d_in, out_full <= 1.
  - If out_full=1: write is dropped, even when the buffer drains on that edge. Software must poll addr 11 before writing.
  - Writes to 00, 01, 11 are ignored.
- Router input:
  - net_ri = ~in_full (forced 0 during reset).
  - When net_si && net_ri: in_buf <= net_di, in_full <= 1.
  - net_si while net_ri=0 is a protocol error; the packet is ignored and in_buf is not corrupted.
  - A processor read of addr 00 and a router write cannot collide, because net_ri=0 whenever in_full=1.
  - After a read clears in_full, net_ri rises on the next cycle.
- Router output:
  - net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity), combinational.
  - net_do = out_buf whenever net_so=1, otherwise 0.
  - On an edge where net_so=1, out_full <= 0.
  - Packet latency from write to injection: at best 1 cycle (write edge, then net_so in the following cycle if the polarity matches).
  - A mismatched VC bit waits until polarity toggles; out_buf remains stable meanwhile.
- Reset mid-operation: both buffers empty immediately; any packet pending in either direction is discarded; d_out = 0.
- All data vectors are big-endian [0:63]; bit 0 is the MSB.

Decomposition:
- Shared package cardinal_nic_pkg:
  - address constants NIC_ADDR_IN_BUF=2'b00, NIC_ADDR_IN_STAT=2'b01, NIC_ADDR_OUT_BUF=2'b10, NIC_ADDR_OUT_STAT=2'b11;
  - DATA_WIDTH;
  - VC_BIT.
- One sub-module, cardinal_nic_slot: a one-entry buffer with a full flag and load/drain strobes. It is instantiated twice (input and output). The top level holds the address decode, the d_out register and the polarity gating.

Test Plan:
- Reset then idle → d_out=0, net_so=0, net_ri=1 after reset deasserts; status reads at 01 and 11 return 0.
- Write 64'h0123_4567_89AB_CDEF to addr 10 with net_ro=1 and polarity=0 (VC bit 0) → net_so=1 next cycle with net_do=64'h0123_4567_89AB_CDEF; addr 11 reads 0 afterwards.
- Write 64'h8000_0000_0000_0001 (VC=1) while polarity=0 → net_so stays 0; polarity toggles to 1 → net_so=1 for one cycle.
- Write a second packet while out_full=1 (net_ro=0) → dropped; once drained, net_do carries the first packet only.
- net_si=1 with net_di=64'hDEAD_BEEF_0000_0001 → net_ri drops to 0; read 01 returns 1; read 00 returns the packet one cycle later; net_ri=1 the following cycle.
- Assert reset with both buffers full → both flags cleared, net_so=0, net_ri=0 during reset and 1 after.

Source files
------------

// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal ring NIC.
// Address map and packet layout used by the NIC and its buffer slots.
package cardinal_nic_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int VC_BIT     = 0;

  localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/cardinal_nic_slot.sv
// One-entry packet buffer with a full flag.
// A load takes priority over a drain on the same edge.
module cardinal_nic_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [0:W-1] load_data,
  input  logic         drain,
  output logic [0:W-1] data,
  output logic         full
);

  logic [0:W-1] data_d, data_q;
  logic         full_d, full_q;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (drain) full_d = 1'b0;
    if (load) begin
      data_d = load_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data = data_q;
  assign full = full_q;

endmodule

// File: rtl/cardinal_nic.sv
// Processor-to-ring network interface: register window plus
// one-entry input and output buffers with polarity-gated injection.
module cardinal_nic #(
  parameter int DATA_WIDTH = cardinal_nic_pkg::DATA_WIDTH,
  parameter int VC_BIT     = cardinal_nic_pkg::VC_BIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:1]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  import cardinal_nic_pkg::*;

  logic                  rd_en, wr_out;
  logic                  in_full, out_full;
  logic                  in_drain, out_load;
  logic                  vc_ok;
  logic [0:DATA_WIDTH-1] in_buf, out_buf;
  logic [0:DATA_WIDTH-1] d_out_d, d_out_q;

  assign rd_en    = nicEn & ~nicWrEn;
  assign wr_out   = nicEn & nicWrEn & (addr == NIC_ADDR_OUT_BUF);
  assign in_drain = rd_en & (addr == NIC_ADDR_IN_BUF);
  // A write into a full slot is dropped even if it drains this edge.
  assign out_load = wr_out & ~out_full;

  assign net_ri = ~reset & ~in_full;
  assign vc_ok  = out_buf[VC_BIT] == net_polarity;
  assign net_so = ~reset & out_full & net_ro & vc_ok;
  assign net_do = net_so ? out_buf : '0;

  cardinal_nic_slot #(.W(DATA_WIDTH)) u_in_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (net_si & net_ri),
    .load_data (net_di),
    .drain     (in_drain),
    .data      (in_buf),
    .full      (in_full)
  );

  cardinal_nic_slot #(.W(DATA_WIDTH)) u_out_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (out_load),
    .load_data (d_in),
    .drain     (net_so),
    .data      (out_buf),
    .full      (out_full)
  );

  always_comb begin
    d_out_d = d_out_q;
    if (rd_en) begin
      unique case (addr)
        NIC_ADDR_IN_BUF:   d_out_d = in_buf;
        NIC_ADDR_IN_STAT:  d_out_d = {{(DATA_WIDTH-1){1'b0}}, in_full};
        NIC_ADDR_OUT_BUF:  d_out_d = '0;
        NIC_ADDR_OUT_STAT: d_out_d = {{(DATA_WIDTH-1){1'b0}}, out_full};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) d_out_q <= '0;
    else       d_out_q <= d_out_d;
  end

  assign d_out = d_out_q;

endmodule
